// File: rtl/rs_encoder.sv
// rs_encoder -- systematic Reed-Solomon RS(255,239) encoder over GF(2^8), t=8.
//
// The message symbols go straight to the output with one cycle of latency.
// Each symbol also feeds a 16-stage LFSR that divides the message by the
// generator polynomial g(x) = prod_{i=0..15} (x + alpha^i). After the k-th
// symbol the encoder spends 16 cycles emitting the remainder, highest degree
// (x^15) first. The decoder then sees all-zero syndromes for an error-free
// codeword.
// Field: primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
//
// Optional build macro:
//   RS_SHORTENED_EN  adds the msg_len input. msg_len is sampled on the first
//                    accept of each frame. Values of 0 or above k select k.
//
// Ports:
//   clk_in     in   clock, rising edge
//   rst_in     in   asynchronous, active-high reset
//   data_in    in   message symbol; the first symbol is the highest-degree term
//   in_valid   in   data_in is valid this cycle
//   in_sop     in   first symbol of a frame; restarts a partial frame
//   msg_len    in   (RS_SHORTENED_EN only) message length of this frame
//   in_ready   out  symbol accepted when in_valid && in_ready
//   data_out   out  registered codeword symbol
//   out_valid  out  data_out is valid
//   out_sop    out  first codeword symbol
//   out_eop    out  last parity symbol
module rs_encoder #(
  parameter int M = 8,    // symbol width
  parameter int K = 239,  // message length
  parameter int T = 8     // correctable symbols
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [M-1:0] data_in,
  input  logic         in_valid,
  input  logic         in_sop,
`ifdef RS_SHORTENED_EN
  input  logic [M-1:0] msg_len,
`endif
  output logic         in_ready,
  output logic [M-1:0] data_out,
  output logic         out_valid,
  output logic         out_sop,
  output logic         out_eop
);

  localparam int NPAR = 2 * T;
  localparam int PW   = $clog2(NPAR);
  localparam logic [M-1:0]  PRIM     = M'(8'h1D);  // 0x11D without the x^8 term
  localparam logic [M-1:0]  K_SYM    = M'(K);
  localparam logic [PW-1:0] PAR_LAST = PW'(NPAR - 1);

  typedef logic [NPAR-1:0][M-1:0] coef_t;
  typedef enum logic {MSG, PARITY} state_t;

  // GF(2^8) multiply by shift-and-add. A constant operand reduces this to a
  // small XOR network.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                          input logic [M-1:0] b);
    logic [M-1:0] acc;
    logic [M-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < M; i++) begin
      if (b[i]) acc ^= sh;
      sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? PRIM : '0);
    end
    return acc;
  endfunction

  // Expand g(x) one root at a time. The result is evaluated at elaboration.
  // The monic x^16 term is implicit.
  function automatic coef_t gen_poly();
    logic [NPAR:0][M-1:0] g;
    logic [M-1:0]         root;
    g    = '0;
    g[0] = M'(1);
    root = M'(1);
    for (int i = 0; i < NPAR; i++) begin
      for (int j = NPAR; j > 0; j--) g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, M'(2));
    end
    return g[NPAR-1:0];
  endfunction

  localparam coef_t G = gen_poly();

  state_t         state, state_n;
  coef_t          parity, parity_n;
  logic [M-1:0]   sym_cnt, sym_cnt_n;
  logic [PW-1:0]  par_cnt, par_cnt_n;
  logic [M-1:0]   data_n;
  logic           valid_n, sop_n, eop_n;
  logic [M-1:0]   fb, cnt_inc, frame_len;
  logic           restart, first;
`ifdef RS_SHORTENED_EN
  logic [M-1:0]   len_q, len_n;
`endif

  assign in_ready = (state == MSG);

  // NOTE: every signal this block writes gets a default first, so no latch can be inferred.
  always_comb begin
    state_n   = state;
    parity_n  = parity;
    sym_cnt_n = sym_cnt;
    par_cnt_n = par_cnt;
    data_n    = data_out;
    valid_n   = 1'b0;
    sop_n     = 1'b0;
    eop_n     = 1'b0;
    fb        = '0;
    restart   = 1'b0;
    first     = 1'b0;
    cnt_inc   = '0;
    frame_len = K_SYM;
`ifdef RS_SHORTENED_EN
    len_n     = len_q;
`endif
    case (state)
      MSG: begin
        if (in_valid) begin
          // A mid-frame in_sop drops the partial remainder and starts over.
          restart = in_sop && (sym_cnt != '0);
          first   = (sym_cnt == '0) || restart;
          fb      = data_in ^ (restart ? '0 : parity[NPAR-1]);
          parity_n[0] = gf_mul(fb, G[0]);
          for (int i = 1; i < NPAR; i++)
            parity_n[i] = (restart ? '0 : parity[i-1]) ^ gf_mul(fb, G[i]);
`ifdef RS_SHORTENED_EN
          if (first)
            frame_len = (msg_len == '0 || msg_len > K_SYM) ? K_SYM : msg_len;
          else
            frame_len = len_q;
          len_n = frame_len;
`endif
          cnt_inc = restart ? M'(1) : sym_cnt + M'(1);
          if (cnt_inc == frame_len) begin
            state_n   = PARITY;
            sym_cnt_n = '0;
          end else begin
            sym_cnt_n = cnt_inc;
          end
          data_n  = data_in;
          valid_n = 1'b1;
          sop_n   = first;
        end
      end
      PARITY: begin
        data_n    = parity[NPAR-1];
        valid_n   = 1'b1;
        parity_n  = {parity[NPAR-2:0], {M{1'b0}}};
        par_cnt_n = par_cnt + 1'b1;
        if (par_cnt == PAR_LAST) begin
          eop_n     = 1'b1;
          state_n   = MSG;
          parity_n  = '0;
          par_cnt_n = '0;
        end
      end
      default: state_n = MSG;
    endcase
  end

  // NOTE: registers use non-blocking assignments so that each one updates from pre-edge values.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= MSG;
      // NOTE: the parity registers are LFSR state, not a memory. They are
      // reset because every frame must start from a zero remainder.
      parity    <= '0;
      sym_cnt   <= '0;
      par_cnt   <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
`ifdef RS_SHORTENED_EN
      len_q     <= K_SYM;
`endif
    end else begin
      state     <= state_n;
      parity    <= parity_n;
      sym_cnt   <= sym_cnt_n;
      par_cnt   <= par_cnt_n;
      data_out  <= data_n;
      out_valid <= valid_n;
      out_sop   <= sop_n;
      out_eop   <= eop_n;
`ifdef RS_SHORTENED_EN
      len_q     <= len_n;
`endif
    end
  end

endmodule

// File: tb/tb_rs_encoder.sv
// tb_rs_encoder -- randomized self-checking bench for rs_encoder.
// The reference computes parity by polynomial long division of m(x)*x^16 by
// g(x), using log/antilog tables. It also evaluates the decoder's syndromes
// on the observed codeword. Define RS_SHORTENED_EN to cover the msg_len port.
module tb_rs_encoder;
  localparam int K    = 239;
  localparam int NPAR = 16;

  typedef int iq_t[$];
  typedef struct {
    int data;
    bit sop;
    bit eop;
    int cyc;
  } obs_t;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [7:0] data_in;
  logic       in_valid, in_sop, in_ready;
  logic [7:0] data_out;
  logic       out_valid, out_sop, out_eop;
`ifdef RS_SHORTENED_EN
  logic [7:0] msg_len;
`endif

  always #5 clk_in = ~clk_in;

  rs_encoder dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
`ifdef RS_SHORTENED_EN
    .msg_len   (msg_len),
`endif
    .in_ready  (in_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .out_sop   (out_sop),
    .out_eop   (out_eop)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- GF(2^8) reference arithmetic ----------------
  int gf_exp[0:509];
  int gf_log[0:255];
  int gl[0:16];        // g(x) coefficients, gl[d] multiplies x^d
  int exp_par[0:15];   // expected parity, index 0 = x^15 coefficient (first out)

  function automatic void build_tables();
    int x = 1;
    for (int i = 0; i < 255; i++) begin
      gf_exp[i]       = x;
      gf_exp[i + 255] = x;
      gf_log[x]       = i;
      x = x << 1;
      if ((x & 256) != 0) x = x ^ 'h11D;
    end
    gf_log[0] = 0;
  endfunction

  function automatic int mul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gf_exp[gf_log[a] + gf_log[b]];
  endfunction

  function automatic void build_gen();
    int nx[0:16];
    for (int d = 0; d <= 16; d++) gl[d] = (d == 0) ? 1 : 0;
    for (int i = 0; i < NPAR; i++) begin
      for (int d = 0; d <= 16; d++)
        nx[d] = ((d > 0) ? gl[d-1] : 0) ^ mul(gl[d], gf_exp[i]);
      for (int d = 0; d <= 16; d++) gl[d] = nx[d];
    end
  endfunction

  // Remainder of m(x)*x^16 divided by g(x), by schoolbook long division.
  function automatic void compute_parity(input iq_t msg);
    int r[$];
    int len = msg.size();
    r = msg;
    for (int j = 0; j < NPAR; j++) r.push_back(0);
    for (int i = 0; i < len; i++) begin
      int c = r[i];
      if (c != 0)
        for (int j = 1; j <= NPAR; j++) r[i+j] = r[i+j] ^ mul(c, gl[16-j]);
    end
    for (int j = 0; j < NPAR; j++) exp_par[j] = r[len + j];
  endfunction

  function automatic iq_t rand_msg(input int len);
    iq_t q;
    for (int i = 0; i < len; i++) q.push_back(int'($urandom_range(0, 255)));
    return q;
  endfunction

  // ---------------- monitor ----------------
  obs_t out_q[$];
  int   acc_q[$];
  int   cyc = 0;
  int   ready_low = 0;

  always @(negedge clk_in) begin
    obs_t o;
    cyc++;
    if (!rst_in) begin
      if (out_valid) begin
        o.data = int'(data_out);
        o.sop  = out_sop;
        o.eop  = out_eop;
        o.cyc  = cyc;
        out_q.push_back(o);
      end
      if (in_valid && in_ready) acc_q.push_back(cyc);
      if (!in_ready) ready_low++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver ----------------
  task automatic clear_obs();
    out_q.delete();
    acc_q.delete();
    ready_low = 0;
  endtask

  task automatic send_sym(input int d, input bit sop, input int gap);
    int waited = 0;
    if (gap > 0) begin
      in_valid = 1'b0;
      in_sop   = 1'b0;
      repeat (gap) @(posedge clk_in);
      #1;
    end
    data_in  = 8'(d);
    in_sop   = sop;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(posedge clk_in); #1;
      waited++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk_in); #1;
  endtask

  task automatic send_frame(input iq_t msg, input int max_gap, input bit sop_first);
    for (int i = 0; i < msg.size(); i++)
      send_sym(msg[i], sop_first && (i == 0),
               (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic idle_wait();
    in_valid = 1'b0;
    in_sop   = 1'b0;
    repeat (22) @(posedge clk_in);
    #1;
  endtask

  // Check one codeword that starts at out_q[s]: pass-through, framing,
  // parity against the model, and decoder syndromes.
  task automatic verify_frame(input string tag, input iq_t msg, input int s);
    int len = msg.size();
    int errs = 0, nsop = 0, neop = 0, nzsyn = 0;
    int cw[$];
    if (out_q.size() < s + len + NPAR) begin
      check({tag, "_short"}, 32'(out_q.size()), 32'(s + len + NPAR));
      return;
    end
    compute_parity(msg);
    for (int i = 0; i < len + NPAR; i++) begin
      cw.push_back(out_q[s+i].data);
      if (i < len && out_q[s+i].data != msg[i]) errs++;
      if (out_q[s+i].sop) nsop++;
      if (out_q[s+i].eop) neop++;
    end
    check({tag, "_msg_errs"}, 32'(errs), 32'd0);
    check({tag, "_sop_first"}, 32'(out_q[s].sop), 32'd1);
    check({tag, "_eop_last"}, 32'(out_q[s+len+NPAR-1].eop), 32'd1);
    check({tag, "_sop_count"}, 32'(nsop), 32'd1);
    check({tag, "_eop_count"}, 32'(neop), 32'd1);
    for (int j = 0; j < NPAR; j++)
      check($sformatf("%s_par%0d", tag, j), 32'(out_q[s+len+j].data), 32'(exp_par[j]));
    for (int i = 0; i < NPAR; i++) begin
      int syn = 0;
      foreach (cw[c]) syn = mul(syn, gf_exp[i]) ^ cw[c];
      if (syn != 0) nzsyn++;
    end
    check({tag, "_syndromes_nonzero"}, 32'(nzsyn), 32'd0);
  endtask

  // Message outputs trail accepts by one cycle, and parity follows without gaps.
  task automatic verify_timing(input string tag, input int len);
    int errs = 0;
    if (acc_q.size() < len || out_q.size() < len + NPAR) begin
      check({tag, "_timing_short"}, 32'(acc_q.size()), 32'(len));
      return;
    end
    for (int i = 0; i < len; i++)
      if (out_q[i].cyc != acc_q[i] + 1) errs++;
    for (int j = 0; j < NPAR; j++)
      if (out_q[len+j].cyc != out_q[len-1].cyc + 1 + j) errs++;
    check({tag, "_timing_errs"}, 32'(errs), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    iq_t msg, msg2;
    int  errs, waited;

    build_tables();
    build_gen();
    rst_in   = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    data_in  = '0;
`ifdef RS_SHORTENED_EN
    msg_len  = '0;
`endif
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    check("rst_out_sop", 32'(out_sop), 32'd0);
    check("rst_out_eop", 32'(out_eop), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // All-zero message: all-zero codeword, 16 cycles of backpressure.
    clear_obs();
    msg.delete();
    for (int i = 0; i < K; i++) msg.push_back(0);
    send_frame(msg, 0, 1'b0);
    idle_wait();
    check("zero_count", 32'(out_q.size()), 32'd255);
    errs = 0;
    foreach (out_q[i]) if (out_q[i].data != 0) errs++;
    check("zero_nonzero_syms", 32'(errs), 32'd0);
    check("zero_ready_low", 32'(ready_low), 32'd16);
    verify_frame("zero", msg, 0);

    // m(x)=1: the parity block is g15..g0.
    clear_obs();
    msg[K-1] = 1;
    send_frame(msg, 0, 1'b1);
    idle_wait();
    verify_frame("unit", msg, 0);
    if (out_q.size() >= K + NPAR)
      for (int j = 0; j < NPAR; j++)
        check($sformatf("gtab_g%0d", 15 - j), 32'(out_q[K+j].data), 32'(gl[15-j]));

    // Random messages with random gaps.
    for (int f = 0; f < 3; f++) begin
      clear_obs();
      msg = rand_msg(K);
      send_frame(msg, 3, 1'($urandom_range(0, 1)));
      idle_wait();
      verify_frame($sformatf("rand%0d", f), msg, 0);
      verify_timing($sformatf("rand%0d", f), K);
    end

    // Back-to-back frames with in_valid held high through the parity phase.
    clear_obs();
    msg  = rand_msg(K);
    msg2 = rand_msg(K);
    send_frame(msg, 0, 1'b1);
    send_frame(msg2, 0, 1'b0);
    idle_wait();
    check("b2b_count", 32'(out_q.size()), 32'd510);
    errs = 0;
    for (int i = 1; i < out_q.size(); i++)
      if (out_q[i].cyc != out_q[i-1].cyc + 1) errs++;
    check("b2b_gaps", 32'(errs), 32'd0);
    verify_frame("b2b_f0", msg, 0);
    verify_frame("b2b_f1", msg2, 255);

    // in_sop on symbol 100 aborts the partial frame.
    clear_obs();
    msg  = rand_msg(99);
    msg2 = rand_msg(K);
    send_frame(msg, 1, 1'b1);
    send_frame(msg2, 1, 1'b1);
    idle_wait();
    check("abort_count", 32'(out_q.size()), 32'(99 + K + NPAR));
    check("abort_sop0", 32'(out_q.size() > 0 ? out_q[0].sop : 1'b0), 32'd1);
    errs = 0;
    foreach (out_q[i]) if (out_q[i].eop) errs++;
    check("abort_total_eops", 32'(errs), 32'd1);
    verify_frame("abort", msg2, 99);

    // Asynchronous reset in the middle of the parity phase.
    clear_obs();
    msg = rand_msg(K);
    send_frame(msg, 0, 1'b1);
    in_valid = 1'b0;
    waited = 0;
    while (in_ready && waited < 10) begin @(posedge clk_in); #1; waited++; end
    check("prst_in_parity", 32'(in_ready), 32'd0);
    repeat (5) @(posedge clk_in);
    #3;
    rst_in = 1'b1;
    #1;
    check("prst_out_valid", 32'(out_valid), 32'd0);
    check("prst_data_out", 32'(data_out), 32'd0);
    check("prst_out_eop", 32'(out_eop), 32'd0);
    check("prst_in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_in = 1'b0;
    @(posedge clk_in); #1;
    clear_obs();
    msg = rand_msg(K);
    send_frame(msg, 2, 1'b0);
    idle_wait();
    check("prst_count", 32'(out_q.size()), 32'd255);
    verify_frame("prst", msg, 0);

`ifdef RS_SHORTENED_EN
    // Shortened frame: msg_len is sampled on the first accept only.
    clear_obs();
    msg = rand_msg(10);
    for (int i = 0; i < 10; i++) begin
      msg_len = (i == 0) ? 8'd10 : 8'($urandom_range(20, 200));
      send_sym(msg[i], 1'b0, int'($urandom_range(0, 2)));
    end
    idle_wait();
    check("short_count", 32'(out_q.size()), 32'd26);
    verify_frame("short", msg, 0);
    msg2.delete();
    for (int i = 0; i < K - 10; i++) msg2.push_back(0);
    foreach (msg[i]) msg2.push_back(msg[i]);
    compute_parity(msg2);
    if (out_q.size() >= 26)
      for (int j = 0; j < NPAR; j++)
        check($sformatf("short_padded_par%0d", j), 32'(out_q[10+j].data), 32'(exp_par[j]));

    // msg_len = 0 selects the full length.
    clear_obs();
    msg = rand_msg(K);
    msg_len = 8'd0;
    send_frame(msg, 0, 1'b1);
    idle_wait();
    check("len0_count", 32'(out_q.size()), 32'd255);
    verify_frame("len0", msg, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
